// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: reset vector, squash word, field positions.
package pc_fetch_stage_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned JIDX_W = 26;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

    // Instruction / address field positions used to build a jump target
    localparam int unsigned JIDX_MSB  = 25;
    localparam int unsigned JIDX_LSB  = 0;
    localparam int unsigned PC_HI_MSB = 31;
    localparam int unsigned PC_HI_LSB = 28;

    // Valid bit of the IF/ID register, viewed as a two-state machine
    typedef enum logic {
        EMPTY = 1'b0,
        LIVE  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_next_pc_sel.sv
// Combinational next-PC selection: jump > branch > stall hold > sequential.
module pc_fetch_stage_next_pc_sel
    import pc_fetch_stage_pkg::*;
(
    input  logic [XLEN-1:0]   pc,
    input  logic [XLEN-1:0]   if_pc_plus4,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              if_valid,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic              stall,
    output logic [XLEN-1:0]   next_pc_c,
    output logic              redirect_c,
    output logic              misalign_c
);

    logic [XLEN-1:0] seq_target;
    logic [XLEN-1:0] br_target;
    logic [XLEN-1:0] jmp_target;
    logic [XLEN-1:0] redir_target;

    // Candidate targets; all additions wrap modulo 2^32
    always_comb begin
        seq_target = pc + XLEN'(4);
        br_target  = if_pc_plus4 + branch_offset;
        jmp_target = {if_pc_plus4[PC_HI_MSB:PC_HI_LSB], jump_index[JIDX_MSB:JIDX_LSB], 2'b00};
    end

    // Priority select; redirects from ID only count when IF/ID holds a live instruction
    always_comb begin
        redirect_c   = if_valid & (jump | branch_taken);
        redir_target = jump ? jmp_target : br_target;
        misalign_c   = 1'b0;
        next_pc_c    = seq_target;
        if (redirect_c) begin
            next_pc_c  = redir_target;
            misalign_c = (redir_target[1:0] != 2'b00);
        end else if (stall) begin
            next_pc_c = pc;
        end
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and sticky misalignment flag.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = pc_fetch_stage_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pc_fetch_stage_pkg::DEFAULT_NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_offset,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic [XLEN-1:0]   instr_in,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   if_pc_plus4,
    output logic [XLEN-1:0]   if_instr,
    output logic              if_valid,
    output logic              misaligned
);

    fetch_state_t    state_q;
    fetch_state_t    state_d;
    logic [XLEN-1:0] next_pc_c;
    logic            redirect_c;
    logic            misalign_c;
    logic            squash_c;

    pc_fetch_stage_next_pc_sel u_next_pc_sel (
        .pc            (pc),
        .if_pc_plus4   (if_pc_plus4),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .if_valid      (if_valid),
        .jump          (jump),
        .branch_taken  (branch_taken),
        .stall         (stall),
        .next_pc_c     (next_pc_c),
        .redirect_c    (redirect_c),
        .misalign_c    (misalign_c)
    );

    assign squash_c = redirect_c | flush;
    assign if_valid = (state_q == LIVE);

    // Valid-bit state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: squash empties IF/ID, stall holds, otherwise a fetch lands
    always_comb begin
        state_d = state_q;
        if (squash_c) begin
            state_d = EMPTY;
        end else if (!stall) begin
            state_d = LIVE;
        end
    end

    // Program counter; the selector already folds in stall and redirect priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc_c;
        end
    end

    // IF/ID payload: squash to NOP, hold on stall, otherwise capture the fetched word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_instr    <= NOP_INSTR;
            if_pc_plus4 <= '0;
        end else if (squash_c) begin
            if_instr    <= NOP_INSTR;
            if_pc_plus4 <= '0;
        end else if (!stall) begin
            if_instr    <= instr_in;
            if_pc_plus4 <= pc + XLEN'(4);
        end
    end

    // Sticky flag for a redirect to a non-word-aligned target
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misaligned <= 1'b0;
        end else if (misalign_c) begin
            misaligned <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed testbench for pc_fetch_stage with a combinational instruction-memory model.
module tb_pc_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] instr_in;
    logic [31:0] pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        misaligned;

    int errors = 0;
    int checks = 0;

    pc_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .instr_in      (instr_in),
        .pc            (pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_instr      (if_instr),
        .if_valid      (if_valid),
        .misaligned    (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address a is a ^ 32'hDEAD_0000
    assign instr_in = pc ^ 32'hDEAD_0000;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_offset = 32'h0; jump_index = 26'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=%h", pc, 32'h0); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=%h", if_instr, 32'h0); end
        checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got=%h want=%h", if_pc_plus4, 32'h0); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_misal got=%b want=0", misaligned); end
        rst = 0;
    endtask

    // Edges 1..3 after reset: sequential fetch from 0
    task automatic test_sequential();
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq1_pc got=%h want=%h", pc, 32'h4); end
        checks++; if (if_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL seq1_instr got=%h want=%h", if_instr, 32'hDEAD_0000); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got=%b want=1", if_valid); end
        checks++; if (if_pc_plus4 !== 32'h4) begin errors++; $display("FAIL seq1_pc4 got=%h want=%h", if_pc_plus4, 32'h4); end
        tick();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq2_pc got=%h want=%h", pc, 32'h8); end
        checks++; if (if_instr !== 32'hDEAD_0004) begin errors++; $display("FAIL seq2_instr got=%h want=%h", if_instr, 32'hDEAD_0004); end
        tick();
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL seq3_pc got=%h want=%h", pc, 32'hC); end
        checks++; if (if_instr !== 32'hDEAD_0008) begin errors++; $display("FAIL seq3_instr got=%h want=%h", if_instr, 32'hDEAD_0008); end
        tick();
        checks++; if (if_pc_plus4 !== 32'h10) begin errors++; $display("FAIL seq4_pc4 got=%h want=%h", if_pc_plus4, 32'h10); end
    endtask

    // if_pc_plus4=0x10, offset -8 -> target 8, one bubble, then mem[8]
    task automatic test_branch();
        branch_taken = 1; branch_offset = 32'hFFFF_FFF8;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h8) begin errors++; $display("FAIL br_pc got=%h want=%h", pc, 32'h8); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL br_valid got=%b want=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL br_squash got=%h want=%h", if_instr, 32'h0); end
        tick();
        checks++; if (if_instr !== 32'hDEAD_0008) begin errors++; $display("FAIL br_fetch got=%h want=%h", if_instr, 32'hDEAD_0008); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL br_valid2 got=%b want=1", if_valid); end
        checks++; if (pc !== 32'hC) begin errors++; $display("FAIL br_pc2 got=%h want=%h", pc, 32'hC); end
    endtask

    // Reach 0x4000_0000 by branch, then jump with stall asserted
    task automatic test_jump_stall();
        branch_taken = 1; branch_offset = 32'h3FFF_FFF4;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h4000_0000) begin errors++; $display("FAIL far_pc got=%h want=%h", pc, 32'h4000_0000); end
        tick();
        checks++; if (if_pc_plus4 !== 32'h4000_0004) begin errors++; $display("FAIL far_pc4 got=%h want=%h", if_pc_plus4, 32'h4000_0004); end
        checks++; if (if_instr !== 32'h9EAD_0000) begin errors++; $display("FAIL far_instr got=%h want=%h", if_instr, 32'h9EAD_0000); end
        jump = 1; jump_index = 26'h000_0040; stall = 1;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL jmp_pc got=%h want=%h", pc, 32'h4000_0100); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL jmp_valid got=%b want=0", if_valid); end
        checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL jmp_pc4 got=%h want=%h", if_pc_plus4, 32'h0); end
        tick();
        checks++; if (if_instr !== 32'h9EAD_0100) begin errors++; $display("FAIL jmp_fetch got=%h want=%h", if_instr, 32'h9EAD_0100); end
    endtask

    // Fresh run to pc=0x20, stall three edges, then resume
    task automatic test_stall();
        rst = 1;
        #2;
        rst = 0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (pc !== 32'h20) begin errors++; $display("FAIL st_pre_pc got=%h want=%h", pc, 32'h20); end
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h20) begin errors++; $display("FAIL st_pc%0d got=%h want=%h", i, pc, 32'h20); end
            checks++; if (if_instr !== 32'hDEAD_001C) begin errors++; $display("FAIL st_instr%0d got=%h want=%h", i, if_instr, 32'hDEAD_001C); end
            checks++; if (if_pc_plus4 !== 32'h20) begin errors++; $display("FAIL st_pc4%0d got=%h want=%h", i, if_pc_plus4, 32'h20); end
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL st_valid%0d got=%b want=1", i, if_valid); end
        end
        stall = 0;
        tick();
        checks++; if (pc !== 32'h24) begin errors++; $display("FAIL st_res_pc got=%h want=%h", pc, 32'h24); end
        checks++; if (if_instr !== 32'hDEAD_0020) begin errors++; $display("FAIL st_res_instr got=%h want=%h", if_instr, 32'hDEAD_0020); end
        checks++; if (if_pc_plus4 !== 32'h24) begin errors++; $display("FAIL st_res_pc4 got=%h want=%h", if_pc_plus4, 32'h24); end
    endtask

    // Branch to 0xFFFF_FFFC, then sequential fetch wraps to 0
    task automatic test_wrap();
        branch_taken = 1; branch_offset = 32'hFFFF_FFD8;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_pc got=%h want=%h", pc, 32'hFFFF_FFFC); end
        tick();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wr_pc2 got=%h want=%h", pc, 32'h0); end
        checks++; if (if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL wr_pc4 got=%h want=%h", if_pc_plus4, 32'h0); end
        checks++; if (if_instr !== 32'h2152_FFFC) begin errors++; $display("FAIL wr_instr got=%h want=%h", if_instr, 32'h2152_FFFC); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL wr_misal got=%b want=0", misaligned); end
    endtask

    // Offset 2 from if_pc_plus4=0 -> target 2, flag sets; repeat while EMPTY is ignored
    task automatic test_misalign();
        branch_taken = 1; branch_offset = 32'h2;
        tick();
        checks++; if (pc !== 32'h2) begin errors++; $display("FAIL ma_pc got=%h want=%h", pc, 32'h2); end
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL ma_flag got=%b want=1", misaligned); end
        tick();
        idle_inputs();
        checks++; if (pc !== 32'h6) begin errors++; $display("FAIL ma_ignore_pc got=%h want=%h", pc, 32'h6); end
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL ma_valid got=%b want=1", if_valid); end
        checks++; if (if_instr !== 32'hDEAD_0002) begin errors++; $display("FAIL ma_instr got=%h want=%h", if_instr, 32'hDEAD_0002); end
        tick();
        checks++; if (misaligned !== 1'b1) begin errors++; $display("FAIL ma_sticky got=%b want=1", misaligned); end
    endtask

    // flush together with stall: IF/ID squashed, pc holds
    task automatic test_flush_stall();
        // pc is 0xA here
        flush = 1; stall = 1;
        tick();
        idle_inputs();
        checks++; if (pc !== 32'hA) begin errors++; $display("FAIL fl_pc got=%h want=%h", pc, 32'hA); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL fl_valid got=%b want=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL fl_instr got=%h want=%h", if_instr, 32'h0); end
        tick();
        checks++; if (if_instr !== 32'hDEAD_000A) begin errors++; $display("FAIL fl_res_instr got=%h want=%h", if_instr, 32'hDEAD_000A); end
        checks++; if (pc !== 32'hE) begin errors++; $display("FAIL fl_res_pc got=%h want=%h", pc, 32'hE); end
    endtask

    // rst pulse between edges clears everything before the next edge
    task automatic test_async_reset();
        #2;
        rst = 1;
        #1;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL ar_pc got=%h want=%h", pc, 32'h0); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got=%b want=0", if_valid); end
        checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL ar_misal got=%b want=0", misaligned); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL ar_instr got=%h want=%h", if_instr, 32'h0); end
        #1;
        rst = 0;
        tick();
        checks++; if (pc !== 32'h4) begin errors++; $display("FAIL ar_pc1 got=%h want=%h", pc, 32'h4); end
        checks++; if (if_instr !== 32'hDEAD_0000) begin errors++; $display("FAIL ar_instr1 got=%h want=%h", if_instr, 32'hDEAD_0000); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump_stall();
        test_stall();
        test_wrap();
        test_misalign();
        test_flush_stall();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Instruction-fetch stage of the MIPS datapath: holds the program counter, drives the instruction-memory address, and registers the fetched instruction into the IF/ID pipeline register. It consumes the branch offset already produced by the word-offset shifter (sign-extended immediate shifted left by 2). It also consumes a jump index, resolves redirects from ID, and handles stall and flush.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- NOP_INSTR, 32'h0000_0000, instruction word inserted on squash/reset.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold PC and IF/ID contents
- flush  input  1  squash the IF/ID contents (valid←0, instr←NOP_INSTR)
- branch_taken  input  1  ID resolved a taken branch for the instruction in IF/ID
- branch_offset  input  32  byte offset, already shifted left by 2
- jump  input  1  ID decoded J/JAL in IF/ID
- jump_index  input  26  instr[25:0] of the jump
- instr_in  input  32  combinational instruction-memory read data at address pc
- pc  output  32  current fetch address (to instruction memory)
- if_pc_plus4  output  32  IF/ID: PC+4 of the held instruction
- if_instr  output  32  IF/ID: held instruction
- if_valid  output  1  IF/ID: held instruction is live
- misaligned  output  1  sticky: a redirect target had target[1:0] ≠ 0

## Operation
- Reset (async, immediate): pc=RESET_PC, if_pc_plus4=0, if_instr=NOP_INSTR, if_valid=0, misaligned=0.
- Targets are combinational from IF/ID: seq = pc+4; br = if_pc_plus4 + branch_offset; jt = {if_pc_plus4[31:28], jump_index, 2'b00}.
- All additions are 32-bit modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0. Negative offsets wrap the same way. No overflow flag.
- Redirect = if_valid & (jump | branch_taken). If if_valid=0, jump and branch_taken are ignored.
- Next-PC priority per edge: redirect by jump (jt) > redirect by branch (br) > stall (hold) > seq.
- A redirect overrides stall.
- IF/ID update per edge:
  - If redirect or flush: if_valid←0, if_instr←NOP_INSTR, if_pc_plus4←0. There is no delay slot; the wrong-path instruction is squashed.
  - Else if stall: all IF/ID contents hold.
  - Else: if_instr←instr_in, if_pc_plus4←pc+4, if_valid←1.
- flush with stall: flush wins on IF/ID; pc still holds unless there is a redirect.
- Misalignment: on a redirect whose selected target has [1:0]≠0, misaligned←1 (sticky until rst). PC loads the target unmodified.
- State is the valid bit: EMPTY (if_valid=0) and LIVE (if_valid=1).
  - EMPTY→LIVE on an edge with no stall, flush, or redirect.
  - LIVE→EMPTY on redirect or flush.
  - LIVE→LIVE or EMPTY→EMPTY otherwise.

## Timing
- Instruction memory is combinational: instr_in is valid in the same cycle pc is driven.
- Fetch latency is 1 cycle: the instruction at pc appears on if_instr after the next rising edge.
- After rst deasserts:
  - first edge: if_instr=mem[RESET_PC], if_valid=1, pc=RESET_PC+4;
  - second edge: mem[RESET_PC+4], and so on.
- Redirect penalty is 1 bubble. At edge N, ID asserts redirect: pc←target and IF/ID is squashed. At edge N+1, IF/ID holds mem[target].
- stall held for k cycles freezes pc and IF/ID for exactly k edges.
- rst asserted mid-operation clears all state immediately, regardless of clk. This includes pending redirects and the misaligned flag.

## Structure
- The shared defines header holds RESET_PC default, NOP_INSTR, and the instruction field positions [25:0] and [31:28].
- Natural sub-module: next_pc_sel. It is combinational and takes pc, if_pc_plus4, branch_offset, jump_index, the redirect controls and stall. It outputs next_pc and the misalignment strobe.
- The top level holds the pc register and the IF/ID register.

## Test plan
- Reset, RESET_PC=0, no stall -> edges 1..3: pc=4,8,12; if_instr=mem[0],mem[4],mem[8]; if_valid=1 from edge 1.
- Taken branch: if_pc_plus4=32'h0000_0010, branch_offset=32'hFFFF_FFF8, branch_taken=1 -> pc=32'h0000_0008; next if_valid=0; following cycle if_instr=mem[8].
- Jump with stall=1: if_pc_plus4=32'h4000_0004, jump_index=26'h000_0040 -> pc=32'h4000_0100; the redirect overrides the stall; IF/ID is squashed.
- Stall 3 cycles at pc=32'h20 -> pc, if_instr and if_pc_plus4 are unchanged for 3 edges; fetch resumes at 32'h24 afterward.
- Wrap and misalign:
  - pc=32'hFFFF_FFFC, no stall -> pc=0 and if_pc_plus4=0.
  - Branch with branch_offset=32'h2 -> misaligned=1; it stays 1 until rst.
- Async reset mid-run: rst pulses between clock edges -> pc=RESET_PC and if_valid=0 immediately, before the next edge.
